// File: rtl/proc_pkg.sv
// proc_pkg: shared opcodes, FSM state encoding and control-bundle layout
package proc_pkg;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_LI   = 4'd6;
  localparam logic [3:0] OP_LW   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;
  localparam logic [3:0] OP_ADDI = 4'd9;
  localparam logic [3:0] OP_BEQZ = 4'd10;
  localparam logic [3:0] OP_BEQ  = 4'd11;
  localparam logic [3:0] OP_J    = 4'd12;
  localparam logic [3:0] OP_NOP0 = 4'd13;
  localparam logic [3:0] OP_NOP1 = 4'd14;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;

  typedef struct packed {
    logic regdest;
    logic alusrc;
    logic memtoreg;
    logic regwrite;
    logic memread;
    logic memwrite;
    logic branch;
    logic jump;
  } strb_t;

  typedef struct packed {
    strb_t s;
    logic  is_halt;
    logic  is_mem;
  } ctrl_t;

  // lw keeps only the memory-read path alive through MEM
  localparam strb_t MEM_HOLD = '{memtoreg: 1'b1, memread: 1'b1, default: 1'b0};
endpackage

// File: rtl/proc_decode.sv
// proc_decode: combinational opcode -> control bundle
// Ports: op (instruction opcode) in, ctrl (strobes + is_halt/is_mem) out
module proc_decode
  import proc_pkg::*;
(
  input  logic [3:0] op,
  output ctrl_t      ctrl
);
  always_comb begin
    ctrl            = '0;
    ctrl.s.regdest  = op <= OP_SHR;
    ctrl.s.regwrite = op <= OP_SHR || op == OP_LI || op == OP_ADDI;
    ctrl.s.alusrc   = op inside {OP_LI, OP_LW, OP_SW, OP_ADDI};
    ctrl.s.memtoreg = op == OP_LW;
    ctrl.s.memread  = op == OP_LW;
    ctrl.s.memwrite = op == OP_SW;
    ctrl.s.branch   = op == OP_BEQZ || op == OP_BEQ;
    ctrl.s.jump     = op == OP_J;
    ctrl.is_halt    = op == OP_HALT;
    ctrl.is_mem     = op == OP_LW;
  end
endmodule

// File: rtl/proc_control_sequencer.sv
// proc_control_sequencer: multi-cycle fetch/decode/execute controller for the 16-bit datapath
// Ports: clk/reset; start; imem_rd/imem_addr/imem_rdata/imem_valid fetch handshake;
//   PC, instruct_reg; registered datapath strobes; dp_jump_signal/dp_out branch feedback;
//   busy, halted, retired (saturating instruction count)
module proc_control_sequencer
  import proc_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int INSTR_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               imem_rd,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic [PC_W-1:0]    PC,
  output logic [INSTR_W-1:0] instruct_reg,
  output logic               regdest,
  output logic               alusrc,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               memread,
  output logic               memwrite,
  output logic               branch,
  output logic               jump,
  input  logic               dp_jump_signal,
  input  logic [15:0]        dp_out,
  output logic               busy,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);
  state_t state, state_d;
  strb_t  strb, strb_d;
  ctrl_t  dec;
  logic   go, last, halt_now, take;
  logic   dp_out_unused;

  proc_decode u_decode (.op(instruct_reg[3:0]), .ctrl(dec));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      strb  <= '0;
    end else begin
      state <= state_d;
      strb  <= strb_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   state_d = start ? S_FETCH : S_IDLE;
      S_FETCH:  state_d = imem_valid ? S_DECODE : S_FETCH;
      S_DECODE: state_d = dec.is_halt ? S_HALT : S_EXEC;
      S_EXEC:   state_d = dec.is_mem ? S_MEM : S_FETCH;
      S_MEM:    state_d = S_FETCH;
      S_HALT:   state_d = start ? S_FETCH : S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // strobes are loaded one edge ahead so they come straight from flops
  always_comb begin
    strb_d    = state == S_DECODE ? dec.s : (state == S_EXEC && dec.is_mem) ? MEM_HOLD : '0;
    imem_rd   = state == S_FETCH;
    imem_addr = PC;
    busy      = state != S_IDLE && state != S_HALT;
    halted    = state == S_HALT;
  end

  assign {regdest, alusrc, memtoreg, regwrite, memread, memwrite, branch, jump} = strb;

  assign go            = start && (state == S_IDLE || state == S_HALT);
  assign last          = (state == S_EXEC && !dec.is_mem) || state == S_MEM;
  assign halt_now      = state == S_DECODE && dec.is_halt;
  assign take          = strb.jump || (strb.branch && dp_jump_signal);
  assign dp_out_unused = ^dp_out[15:PC_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC           <= RESET_PC;
      instruct_reg <= '0;
      retired      <= '0;
    end else begin
      if (state == S_FETCH && imem_valid) instruct_reg <= imem_rdata;
      if (go) PC <= RESET_PC;
      else if (last) PC <= take ? dp_out[PC_W-1:0] : PC + PC_W'(1);
      if (go) retired <= '0;
      else if (last || halt_now) retired <= retired + CNT_W'(~&retired);
    end
  end
endmodule
